// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, opcode constants and the cc-modify test.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int CC_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADC  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDS = 6'b010000;
  localparam logic [OP_W-1:0] OP_SUBS = 6'b010100;

  // Opcodes whose top two bits match this value write the condition codes.
  localparam logic [1:0] CC_MOD = 2'b01;

  function automatic logic is_cc_mod(input logic [OP_W-1:0] op);
    return op[5:4] == CC_MOD;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. Combinational one-hot grant while enabled;
// priority flips to the other requester after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // prio: index of the requester that wins a tie; requester 0 after reset.
  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  prio <= 1'b0;
    else if (|gnt) prio <= gnt[0];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: IDLE grants, EXEC drives
// the ALU and captures its result, RESP holds the response until consumed.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic [CC_W-1:0]   rsp_nzcv,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_ci,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic [CC_W-1:0]   ccr
);

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt;
  logic            owner;
  logic            arb_en;

  // Gating with reset_n keeps req_ready low for the whole reset window.
  assign arb_en    = (state == IDLE) && reset_n;
  assign req_ready = gnt;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req     (req_valid),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = '0;
    case (state)
      IDLE: if (|gnt) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The ALU drive registers double as the operand latch; they load on the
  // grant edge and then hold until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= 1'b0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ci   <= 1'b0;
      rsp_y    <= '0;
      rsp_nzcv <= '0;
      ccr      <= '0;
    end else begin
      if (|gnt) begin
        owner  <= gnt[1];
        alu_op <= gnt[1] ? req_op1 : req_op0;
        alu_a  <= gnt[1] ? req_a1  : req_a0;
        alu_b  <= gnt[1] ? req_b1  : req_b0;
        // ccr only changes at the end of EXEC, so sampling C here is what
        // the ALU sees throughout EXEC.
        alu_ci <= ccr[1];
      end
      if (state == EXEC) begin
        rsp_y    <= alu_y;
        rsp_nzcv <= {alu_n, alu_z, alu_c, alu_v};
        if (is_cc_mod(alu_op)) ccr <= {alu_n, alu_z, alu_c, alu_v};
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU hooked to its ALU port.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]  req_op0, req_op1, alu_op;
  logic [31:0] req_a0, req_a1, req_b0, req_b1, rsp_y, alu_a, alu_b, alu_y;
  logic [3:0]  rsp_nzcv, ccr;
  logic        alu_ci, alu_n, alu_z, alu_c, alu_v;
  logic [32:0] sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_nzcv(rsp_nzcv),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .ccr(ccr)
  );

  // Behavioural ALU: 0=ADD, 8=ADC, 4=SUB (C = no borrow), 1=AND.
  always_comb begin
    sum   = '0;
    alu_v = 1'b0;
    case (alu_op[3:0])
      4'h0: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'h8: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ci};
        alu_v = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'h4: begin
        sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_v = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'h1:    sum = {1'b0, alu_a & alu_b};
      default: sum = {1'b0, alu_a ^ alu_b};
    endcase
    alu_y = sum[31:0];
    alu_c = sum[32];
    alu_n = sum[31];
    alu_z = (sum[31:0] == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else         begin req_op1 = op; req_a1 = a; req_b1 = b; end
  endtask

  // Single request entered at a negedge in IDLE; checks grant, EXEC drive,
  // the 2-cycle response latency, the response payload and ccr.
  task automatic run_op(input int id, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ey, input logic [3:0] enzcv,
                        input logic [3:0] eccr, input logic eci);
    logic [1:0] oh;
    oh = (id == 0) ? 2'b01 : 2'b10;
    set_req(id, op, a, b);
    req_valid = oh;
    #1 check_eq("grant", {30'd0, req_ready}, {30'd0, oh});
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_eq("exec_op", {26'd0, alu_op}, {26'd0, op});
    check_eq("exec_a", alu_a, a);
    check_eq("exec_b", alu_b, b);
    check_eq("exec_ci", {31'd0, alu_ci}, {31'd0, eci});
    check_eq("exec_no_rsp", {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    check_eq("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
    check_eq("rsp_y", rsp_y, ey);
    check_eq("rsp_nzcv", {28'd0, rsp_nzcv}, {28'd0, enzcv});
    check_eq("ccr", {28'd0, ccr}, {28'd0, eccr});
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = '0; rsp_ready = '0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check_eq("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_y", rsp_y, 32'd0);
    check_eq("rst_ccr", {28'd0, ccr}, 32'd0);
    check_eq("rst_alu_op", {26'd0, alu_op}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Signed overflow add, cc-modifying.
    run_op(0, 6'b010000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 4'b1001, 1'b0);
    // Equal subtract sets Z and C.
    run_op(1, 6'b010100, 32'h12, 32'h12, 32'h0, 4'b0110, 4'b0110, 1'b0);
    // Non-cc op leaves ccr alone.
    run_op(0, 6'b000001, 32'hF0, 32'h0F, 32'h0, 4'b0100, 4'b0110, 1'b1);
    // Add-with-carry picks up C=1 from ccr.
    run_op(1, 6'b001000, 32'd5, 32'd3, 32'd9, 4'b0000, 4'b0110, 1'b1);

    // Backpressure: response held, other requester waits, wrong rsp_ready ignored.
    set_req(0, 6'b000000, 32'd100, 32'd23);
    req_valid = 2'b01;
    #1 check_eq("hold_grant0", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    set_req(1, 6'b000000, 32'd1, 32'd1);
    req_valid = 2'b10;
    #1 check_eq("exec_no_grant", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("hold_valid", {30'd0, rsp_valid}, 32'd1);
      check_eq("hold_y", rsp_y, 32'd123);
      check_eq("hold_no_grant", {30'd0, req_ready}, 32'd0);
      rsp_ready = (i == 2) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check_eq("waiter_grant1", {30'd0, req_ready}, 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    check_eq("waiter_valid", {30'd0, rsp_valid}, 32'd2);
    check_eq("waiter_y", rsp_y, 32'd2);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;

    // Reset in EXEC discards the op: everything zero, no response, ccr cleared.
    set_req(0, 6'b010000, 32'h8000_0000, 32'h8000_0000);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    reset_n = 1'b0;
    #1;
    check_eq("rx_req_ready", {30'd0, req_ready}, 32'd0);
    check_eq("rx_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_eq("rx_rsp_y", rsp_y, 32'd0);
    check_eq("rx_nzcv", {28'd0, rsp_nzcv}, 32'd0);
    check_eq("rx_ccr", {28'd0, ccr}, 32'd0);
    check_eq("rx_alu_op", {26'd0, alu_op}, 32'd0);
    check_eq("rx_alu_a", alu_a, 32'd0);
    check_eq("rx_alu_b", alu_b, 32'd0);
    check_eq("rx_alu_ci", {31'd0, alu_ci}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_eq("rx_after_valid", {30'd0, rsp_valid}, 32'd0);
      check_eq("rx_after_ccr", {28'd0, ccr}, 32'd0);
    end

    // Both requesters continuously valid from reset: strict alternation 0,1,0,1.
    do_reset();
    set_req(0, 6'b000000, 32'd1, 32'd2);
    set_req(1, 6'b000000, 32'd10, 32'd20);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] oh;
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1 check_eq("rr_grant", {30'd0, req_ready}, {30'd0, oh});
      @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("rr_valid", {30'd0, rsp_valid}, {30'd0, oh});
      check_eq("rr_y", rsp_y, (k % 2 == 0) ? 32'd3 : 32'd30);
      rsp_ready = oh;
      @(negedge clk);
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
